gemm_in_packer: RTL

- Upstream feeder for the GEMM butterfly stage.
- Accepts a serial stream of complex SFP samples through a valid/ready handshake and packs them, 4 at a time, into the 4-lane real/imag vectors the GEMM consumes.
- Drives the GEMM size-select control with the required hold time.
- Tracks the fixed GEMM pipeline latency so downstream logic gets a result-valid/last strobe aligned with the GEMM output registers.

---
 rtl/gemm_in_packer.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/gemm_in_packer.sv
// gemm_in_packer: serial complex-sample to 4-lane vector packer feeding the GEMM
// butterfly stage, plus a latency tracker aligned with the GEMM output registers.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   cfg_size4         transform size select, sampled with the first sample of a group
//   in_valid/in_ready sample handshake; in_ready is registered
//   in_real/in_imag   sample data (one SFP word each)
//   in_last           last sample of a frame; closes the current group
//   gemm_real/imag    packed vectors, lane 3 in the top bits
//   gemm_control      GEMM control, held until the next issue
//   gemm_start        one-cycle pulse when a vector is issued
//   res_valid/last    GEMM_LATENCY cycles after gemm_start
//   frame_cnt         completed frames (res_valid && res_last), wraps at 2^16
module gemm_in_packer #(
  parameter int FORMAT_WIDTH = 9,
  parameter int GEMM_LATENCY = 4,
  parameter int MIN_GAP      = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_size4,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [FORMAT_WIDTH-1:0]   in_real,
  input  logic [FORMAT_WIDTH-1:0]   in_imag,
  input  logic                      in_last,
  output logic [4*FORMAT_WIDTH-1:0] gemm_real,
  output logic [4*FORMAT_WIDTH-1:0] gemm_imag,
  output logic                      gemm_control,
  output logic                      gemm_start,
  output logic                      res_valid,
  output logic                      res_last,
  output logic [15:0]               frame_cnt
);

  localparam int NUM_LANES = 4;
  localparam int FW        = FORMAT_WIDTH;
  localparam int HW        = (MIN_GAP > 1) ? $clog2(MIN_GAP + 1) : 1;
  localparam logic [HW-1:0] HOLD_INIT = HW'((MIN_GAP > 1) ? MIN_GAP - 2 : 0);

  localparam logic [1:0] S_FILL  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  typedef logic [NUM_LANES-1:0][FW-1:0] vec_t;

  logic [1:0]  st_q, st_d;
  logic [1:0]  lane_q, lane_d;
  logic [1:0]  idx;
  logic [HW-1:0] hold_q, hold_d;
  logic        ready_q, ready_d;
  logic        size_q, size_d;
  logic        glast_q, glast_d;
  logic        start_q, start_d;
  logic        ctrl_q, ctrl_d;
  vec_t        buf_re_q, buf_re_d, buf_im_q, buf_im_d;
  vec_t        g_re_q, g_re_d, g_im_q, g_im_d;
  vec_t        mrg_re, mrg_im;
  logic        accept;

  logic [GEMM_LATENCY-1:0] vld_pipe_q, lst_pipe_q;
  logic [GEMM_LATENCY:0]   vld_sh, lst_sh;
  logic [15:0]             frame_cnt_q;

  // ready_q is only ever set while in FILL, so it doubles as the FILL qualifier.
  assign accept = in_valid & ready_q;

  // Lane being written: lane_q counts filled lanes, lanes fill from 3 downward.
  assign idx = ~lane_q;

  // Merged view of the group with the incoming sample in place: lanes above
  // idx come from the buffer, lanes below idx read as +0.0 so an early in_last
  // zero-pads without ever clearing the buffer.
  for (genvar j = 0; j < NUM_LANES; j++) begin : g_lane
    assign mrg_re[j] = (2'(j) == idx) ? in_real :
                       ((2'(j) > idx) ? buf_re_q[j] : '0);
    assign mrg_im[j] = (2'(j) == idx) ? in_imag :
                       ((2'(j) > idx) ? buf_im_q[j] : '0);
  end

  always_comb begin
    st_d     = st_q;
    lane_d   = lane_q;
    hold_d   = hold_q;
    size_d   = size_q;
    glast_d  = glast_q;
    start_d  = 1'b0;
    ctrl_d   = ctrl_q;
    buf_re_d = buf_re_q;
    buf_im_d = buf_im_q;
    g_re_d   = g_re_q;
    g_im_d   = g_im_q;
    case (st_q)
      S_FILL: begin
        if (accept) begin
          buf_re_d = mrg_re;
          buf_im_d = mrg_im;
          if (lane_q == 2'd0) size_d = cfg_size4;
          if (lane_q == 2'd3 || in_last) begin
            // Output registers load at the closing edge so the vector is on
            // the GEMM inputs during the ISSUE cycle, alongside gemm_start.
            g_re_d  = mrg_re;
            g_im_d  = mrg_im;
            ctrl_d  = (lane_q == 2'd0) ? cfg_size4 : size_q;
            glast_d = in_last;
            start_d = 1'b1;
            lane_d  = 2'd0;
            st_d    = S_ISSUE;
          end else begin
            lane_d = lane_q + 2'd1;
          end
        end
      end
      S_ISSUE: begin
        if (MIN_GAP > 1) begin
          st_d   = S_HOLD;
          hold_d = HOLD_INIT;
        end else begin
          st_d = S_FILL;
        end
      end
      S_HOLD: begin
        if (hold_q == '0) st_d = S_FILL;
        else              hold_d = hold_q - HW'(1);
      end
      default: st_d = S_FILL;
    endcase
    ready_d = (st_d == S_FILL);
  end

  assign vld_sh = {vld_pipe_q, start_q};
  assign lst_sh = {lst_pipe_q, glast_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q        <= S_FILL;
      lane_q      <= '0;
      hold_q      <= '0;
      ready_q     <= 1'b0;
      size_q      <= 1'b0;
      glast_q     <= 1'b0;
      start_q     <= 1'b0;
      ctrl_q      <= 1'b0;
      buf_re_q    <= '0;
      buf_im_q    <= '0;
      g_re_q      <= '0;
      g_im_q      <= '0;
      vld_pipe_q  <= '0;
      lst_pipe_q  <= '0;
      frame_cnt_q <= '0;
    end else begin
      st_q       <= st_d;
      lane_q     <= lane_d;
      hold_q     <= hold_d;
      ready_q    <= ready_d;
      size_q     <= size_d;
      glast_q    <= glast_d;
      start_q    <= start_d;
      ctrl_q     <= ctrl_d;
      buf_re_q   <= buf_re_d;
      buf_im_q   <= buf_im_d;
      g_re_q     <= g_re_d;
      g_im_q     <= g_im_d;
      vld_pipe_q <= vld_sh[GEMM_LATENCY-1:0];
      lst_pipe_q <= lst_sh[GEMM_LATENCY-1:0];
      if (vld_pipe_q[GEMM_LATENCY-1] && lst_pipe_q[GEMM_LATENCY-1])
        frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign in_ready     = ready_q;
  assign gemm_real    = g_re_q;
  assign gemm_imag    = g_im_q;
  assign gemm_control = ctrl_q;
  assign gemm_start   = start_q;
  assign res_valid    = vld_pipe_q[GEMM_LATENCY-1];
  assign res_last     = vld_pipe_q[GEMM_LATENCY-1] & lst_pipe_q[GEMM_LATENCY-1];
  assign frame_cnt    = frame_cnt_q;

endmodule
